// File: rtl/hvac_scheduler.sv
// hvac_scheduler
//   Sequences the room heating/cooling plant from 5-bit temperature samples.
//   It adds hysteresis, a minimum run time, a post-run lockout and a
//   sensor-timeout fault in front of the heater and cooler drive lines.
//
//   Ports
//     clk_i          system clock, everything on the rising edge
//     rst_i          synchronous, active-high reset
//     enable_i       plant is allowed to run
//     temp_valid_i   one-cycle strobe: temperature_i holds a new sample
//     temperature_i  unsigned degC sample
//     heating_o      heater drive
//     cooling_o      cooler drive
//     lockout_o      high while the post-run lockout is active
//     fault_o        high while in sensor-timeout fault
//
//   state | meaning
//   IDLE  | plant off, waiting for a threshold crossing
//   HEAT  | heater driven, minimum run time counting
//   COOL  | cooler driven, minimum run time counting
//   LOCK  | plant off for LOCKOUT cycles after any run or fault
//   FAULT | no sample for TIMEOUT cycles, plant off until the next sample
module hvac_scheduler #(
    parameter logic [4:0] HEAT_ON  = 5'd18,
    parameter logic [4:0] HEAT_OFF = 5'd20,
    parameter logic [4:0] COOL_ON  = 5'd22,
    parameter logic [4:0] COOL_OFF = 5'd20,
    parameter int unsigned MIN_RUN = 4,
    parameter int unsigned LOCKOUT = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       temp_valid_i,
    input  logic [4:0] temperature_i,
    output logic       heating_o,
    output logic       cooling_o,
    output logic       lockout_o,
    output logic       fault_o
);

    localparam int RW = $clog2(MIN_RUN + 1);
    localparam int LW = $clog2(LOCKOUT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [RW-1:0] RUN_LAST  = RW'(MIN_RUN - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAT,
        S_COOL,
        S_LOCK,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      temp_q;
    logic            temp_ok_q;
    logic [WW-1:0]   wd_q, wd_d;
    logic [RW-1:0]   run_q, run_d;
    logic [LW-1:0]   lock_q, lock_d;
    logic            timeout;

    // The strobe of this very cycle counts as activity, so a sample arriving
    // on the last allowed cycle still prevents the fault.
    assign timeout = (wd_q == WD_LAST) && !temp_valid_i;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        lock_d  = lock_q;

        if (temp_valid_i)
            wd_d = '0;
        else if (wd_q == WD_LAST)
            wd_d = wd_q;
        else
            wd_d = wd_q + 1'b1;

        if (timeout) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable_i && temp_ok_q) begin
                        if (temp_q <= HEAT_ON) begin
                            state_d = S_HEAT;
                            run_d   = '0;
                        end else if (temp_q >= COOL_ON) begin
                            state_d = S_COOL;
                            run_d   = '0;
                        end
                    end
                end
                S_HEAT, S_COOL: begin
                    if (run_q != RUN_LAST)
                        run_d = run_q + 1'b1;
                    // run_q saturates at MIN_RUN-1, reached on the last cycle
                    // of the minimum run.
                    if (!enable_i ||
                        ((run_q == RUN_LAST) &&
                         (((state_q == S_HEAT) && (temp_q >= HEAT_OFF)) ||
                          ((state_q == S_COOL) && (temp_q <= COOL_OFF))))) begin
                        state_d = S_LOCK;
                        lock_d  = '0;
                    end
                end
                S_LOCK: begin
                    if (lock_q == LOCK_LAST)
                        state_d = S_IDLE;
                    else
                        lock_d = lock_q + 1'b1;
                end
                S_FAULT: begin
                    if (temp_valid_i) begin
                        state_d = S_LOCK;
                        lock_d  = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            temp_q    <= '0;
            temp_ok_q <= 1'b0;
            wd_q      <= '0;
            run_q     <= '0;
            lock_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            run_q   <= run_d;
            lock_q  <= lock_d;
            if (temp_valid_i) begin
                temp_q    <= temperature_i;
                temp_ok_q <= 1'b1;
            end
        end
    end

    assign heating_o = (state_q == S_HEAT);
    assign cooling_o = (state_q == S_COOL);
    assign lockout_o = (state_q == S_LOCK);
    assign fault_o   = (state_q == S_FAULT);

endmodule
